// File: rtl/iir_coeff_bank_ctrl.sv
// Coefficient bank controller for the 2nd-order IIR datapath.
// Software fills a shadow bank (b0, b1, b2, a1, a2, gain) one word at a time.
// A commit swaps the whole shadow set into the active bank on a sample boundary.
// An optional history clear then holds filt_clear high for CLR_CYCLES cycles.
module iir_coeff_bank_ctrl #(
  parameter int IN_COEFF_WIDTH = 32,
  parameter int COEFF_WIDTH    = 16,
  parameter int CLR_CYCLES     = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [2:0]                      wr_addr,
  input  logic signed [IN_COEFF_WIDTH-1:0] wr_data,
  input  logic                            commit,
  input  logic                            clear_on_commit,
  input  logic                            sample_en,
  output logic signed [COEFF_WIDTH-1:0]   b0_out,
  output logic signed [COEFF_WIDTH-1:0]   b1_out,
  output logic signed [COEFF_WIDTH-1:0]   b2_out,
  output logic signed [COEFF_WIDTH-1:0]   a1_out,
  output logic signed [COEFF_WIDTH-1:0]   a2_out,
  output logic signed [COEFF_WIDTH-1:0]   gain_out,
  output logic                            filt_clear,
  output logic                            busy,
  output logic                            commit_done,
  output logic                            wr_err,
  output logic                            sat_flag
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    SWAP  = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int NUM_COEFFS = 6;

  // Saturation limits of the stored coefficient, and the same limits widened
  // to the write-word width so the comparison happens in full precision.
  localparam logic signed [COEFF_WIDTH-1:0] COEFF_MAX = {1'b0, {(COEFF_WIDTH-1){1'b1}}};
  localparam logic signed [COEFF_WIDTH-1:0] COEFF_MIN = {1'b1, {(COEFF_WIDTH-1){1'b0}}};
  localparam logic signed [IN_COEFF_WIDTH-1:0] IN_MAX = IN_COEFF_WIDTH'(COEFF_MAX);
  localparam logic signed [IN_COEFF_WIDTH-1:0] IN_MIN = IN_COEFF_WIDTH'(COEFF_MIN);
  localparam logic [7:0] CLR_LAST = 8'(CLR_CYCLES);

  state_t state_q, state_d;
  logic   clr_req_q, clr_req_d;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  logic signed [COEFF_WIDTH-1:0] shadow_q [NUM_COEFFS];
  logic signed [COEFF_WIDTH-1:0] shadow_d [NUM_COEFFS];
  logic signed [COEFF_WIDTH-1:0] active_q [NUM_COEFFS];
  logic signed [COEFF_WIDTH-1:0] active_d [NUM_COEFFS];
  logic filt_clear_q, filt_clear_d;
  logic busy_q, busy_d;
  logic commit_done_q, commit_done_d;
  logic wr_err_q, wr_err_d;
  logic sat_flag_q, sat_flag_d;

  logic wr_over;
  logic wr_under;
  logic signed [COEFF_WIDTH-1:0] wr_clamped;

  // Clamp the incoming word to the signed coefficient range.
  always_comb begin
    wr_over    = (wr_data > IN_MAX);
    wr_under   = (wr_data < IN_MIN);
    wr_clamped = wr_data[COEFF_WIDTH-1:0];
    if (wr_over) begin
      wr_clamped = COEFF_MAX;
    end else if (wr_under) begin
      wr_clamped = COEFF_MIN;
    end
  end

  // Shadow write path: accepted only in IDLE with a valid index, otherwise flagged.
  always_comb begin
    shadow_d   = shadow_q;
    sat_flag_d = sat_flag_q;
    wr_err_d   = 1'b0;
    if (wr_en) begin
      if ((state_q == IDLE) && (wr_addr <= 3'd5)) begin
        shadow_d[wr_addr] = wr_clamped;
        if (wr_over || wr_under) begin
          sat_flag_d = 1'b1;
        end
      end else begin
        wr_err_d = 1'b1;
      end
    end
  end

  // Commit sequencer: arm, wait for a sample strobe, swap, optional clear, done.
  always_comb begin
    state_d       = state_q;
    clr_req_d     = clr_req_q;
    clr_cnt_d     = clr_cnt_q;
    active_d      = active_q;
    filt_clear_d  = 1'b0;
    commit_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit) begin
          state_d   = ARMED;
          clr_req_d = clear_on_commit;
        end
      end
      ARMED: begin
        if (sample_en) begin
          state_d = SWAP;
        end
      end
      SWAP: begin
        active_d = shadow_q;
        if (clr_req_q) begin
          state_d      = CLEAR;
          filt_clear_d = 1'b1;
          clr_cnt_d    = 8'd1;
        end else begin
          state_d       = DONE;
          commit_done_d = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt_q >= CLR_LAST) begin
          state_d       = DONE;
          commit_done_d = 1'b1;
        end else begin
          clr_cnt_d    = clr_cnt_q + 8'd1;
          filt_clear_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, bank and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      clr_req_q     <= 1'b0;
      clr_cnt_q     <= 8'd0;
      filt_clear_q  <= 1'b0;
      busy_q        <= 1'b0;
      commit_done_q <= 1'b0;
      wr_err_q      <= 1'b0;
      sat_flag_q    <= 1'b0;
      for (int i = 0; i < NUM_COEFFS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      clr_req_q     <= clr_req_d;
      clr_cnt_q     <= clr_cnt_d;
      filt_clear_q  <= filt_clear_d;
      busy_q        <= busy_d;
      commit_done_q <= commit_done_d;
      wr_err_q      <= wr_err_d;
      sat_flag_q    <= sat_flag_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign b0_out      = active_q[0];
  assign b1_out      = active_q[1];
  assign b2_out      = active_q[2];
  assign a1_out      = active_q[3];
  assign a2_out      = active_q[4];
  assign gain_out    = active_q[5];
  assign filt_clear  = filt_clear_q;
  assign busy        = busy_q;
  assign commit_done = commit_done_q;
  assign wr_err      = wr_err_q;
  assign sat_flag    = sat_flag_q;

endmodule

// File: tb/tb_iir_coeff_bank_ctrl.sv
// Directed self-checking bench for iir_coeff_bank_ctrl.
// Inputs change #1 after each rising edge; outputs are checked at the same point.
module tb_iir_coeff_bank_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        commit;
  logic        clear_on_commit;
  logic        sample_en;
  logic [15:0] b0_out, b1_out, b2_out, a1_out, a2_out, gain_out;
  logic        filt_clear, busy, commit_done, wr_err, sat_flag;

  int assertCount = 0;
  int failCount   = 0;
  int doneCount   = 0;
  int clearCount  = 0;
  int doneSnap;
  int clearSnap;

  iir_coeff_bank_ctrl #(
    .IN_COEFF_WIDTH(32),
    .COEFF_WIDTH(16),
    .CLR_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit(commit),
    .clear_on_commit(clear_on_commit),
    .sample_en(sample_en),
    .b0_out(b0_out),
    .b1_out(b1_out),
    .b2_out(b2_out),
    .a1_out(a1_out),
    .a2_out(a2_out),
    .gain_out(gain_out),
    .filt_clear(filt_clear),
    .busy(busy),
    .commit_done(commit_done),
    .wr_err(wr_err),
    .sat_flag(sat_flag)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Count commit_done pulses and filt_clear cycles mid-cycle
  always @(negedge clk) begin
    if (commit_done === 1'b1) doneCount++;
    if (filt_clear === 1'b1) clearCount++;
  end

  // Hard time limit so the bench can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [31:0] data,
                               input logic cm, input logic coc, input logic se);
    wr_en           = we;
    wr_addr         = addr;
    wr_data         = data;
    commit          = cm;
    clear_on_commit = coc;
    sample_en       = se;
    @(posedge clk);
    #1;
    wr_en           = 1'b0;
    commit          = 1'b0;
    clear_on_commit = 1'b0;
    sample_en       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n           = 1'b0;
    wr_en           = 1'b0;
    wr_addr         = 3'd0;
    wr_data         = 32'h0;
    commit          = 1'b0;
    clear_on_commit = 1'b0;
    sample_en       = 1'b0;
    idle(2);

    // Reset state
    checkOutput("rst_b0", b0_out, 32'h0);
    checkOutput("rst_gain", gain_out, 32'h0);
    checkOutput("rst_busy", busy, 32'h0);
    checkOutput("rst_filt_clear", filt_clear, 32'h0);
    checkOutput("rst_sat", sat_flag, 32'h0);
    checkOutput("rst_done", commit_done, 32'h0);
    rst_n = 1'b1;
    idle(1);

    // Test 1: write b0, commit without clear, swap 2 cycles after sample_en
    $display("[TB] test 1: basic commit");
    doneSnap  = doneCount;
    clearSnap = clearCount;
    applyStimulus(1'b1, 3'd0, 32'h0000_4000, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_wr_err", wr_err, 32'h0);
    checkOutput("t1_sat", sat_flag, 32'h0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_busy_armed", busy, 32'h1);
    idle(4);
    checkOutput("t1_b0_before", b0_out, 32'h0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1_b0_t1", b0_out, 32'h0);
    checkOutput("t1_done_t1", commit_done, 32'h0);
    idle(1);
    checkOutput("t1_b0_t2", b0_out, 32'h4000);
    checkOutput("t1_b1_t2", b1_out, 32'h0);
    checkOutput("t1_a1_t2", a1_out, 32'h0);
    checkOutput("t1_done_t2", commit_done, 32'h1);
    checkOutput("t1_filt_clear", filt_clear, 32'h0);
    idle(1);
    checkOutput("t1_done_t3", commit_done, 32'h0);
    checkOutput("t1_busy_t3", busy, 32'h0);
    checkOutput("t1_done_count", doneCount - doneSnap, 32'd1);
    checkOutput("t1_clear_count", clearCount - clearSnap, 32'd0);

    // Test 2: saturating writes, gain write, sticky sat_flag
    $display("[TB] test 2: saturation");
    applyStimulus(1'b1, 3'd3, 32'h0001_2345, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_sat_hi", sat_flag, 32'h1);
    applyStimulus(1'b1, 3'd4, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd5, 32'h0000_0123, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    checkOutput("t2_a1_max", a1_out, 32'h7FFF);
    checkOutput("t2_a2_min", a2_out, 32'h8000);
    checkOutput("t2_gain", gain_out, 32'h0123);
    checkOutput("t2_b0_held", b0_out, 32'h4000);
    idle(1);
    applyStimulus(1'b1, 3'd0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    checkOutput("t2_sat_sticky", sat_flag, 32'h1);
    checkOutput("t2_b0_not_live", b0_out, 32'h4000);

    // Test 3: commit with history clear, CLR_CYCLES = 4
    $display("[TB] test 3: commit with clear");
    doneSnap  = doneCount;
    clearSnap = clearCount;
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 1'b0);
    idle(1);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_fc_t1", filt_clear, 32'h0);
    idle(1);
    checkOutput("t3_b0_t2", b0_out, 32'h0100);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_fc_high", filt_clear, 32'h1);
      checkOutput("t3_done_low", commit_done, 32'h0);
      idle(1);
    end
    checkOutput("t3_fc_fell", filt_clear, 32'h0);
    checkOutput("t3_done", commit_done, 32'h1);
    checkOutput("t3_busy_done", busy, 32'h1);
    idle(1);
    checkOutput("t3_busy_low", busy, 32'h0);
    checkOutput("t3_clear_count", clearCount - clearSnap, 32'd4);
    checkOutput("t3_done_count", doneCount - doneSnap, 32'd1);

    // Test 4: rejected writes (bad address, write while ARMED)
    $display("[TB] test 4: rejected writes");
    applyStimulus(1'b1, 3'd0, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_good_wr_err", wr_err, 32'h0);
    applyStimulus(1'b1, 3'd6, 32'h0000_0777, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_addr6_err", wr_err, 32'h1);
    idle(1);
    checkOutput("t4_err_pulse", wr_err, 32'h0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd0, 32'h0000_5555, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_armed_err", wr_err, 32'h1);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("t4_err_pulse2", wr_err, 32'h0);
    idle(1);
    checkOutput("t4_b0_kept", b0_out, 32'h0200);
    checkOutput("t4_b1_kept", b1_out, 32'h0);
    checkOutput("t4_a1_kept", a1_out, 32'h7FFF);
    idle(1);

    // Test 5: commit with same-cycle sample_en, extra commit during CLEAR
    $display("[TB] test 5: strobe alignment and ignored commit");
    doneSnap = doneCount;
    applyStimulus(1'b1, 3'd0, 32'h0000_0300, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 1'b1);
    idle(2);
    checkOutput("t5_no_swap", b0_out, 32'h0200);
    checkOutput("t5_still_busy", busy, 32'h1);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    checkOutput("t5_b0_swapped", b0_out, 32'h0300);
    checkOutput("t5_fc_high", filt_clear, 32'h1);
    idle(1);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(2);
    checkOutput("t5_done", commit_done, 32'h1);
    idle(1);
    checkOutput("t5_idle", busy, 32'h0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(4);
    checkOutput("t5_stay_idle", busy, 32'h0);
    checkOutput("t5_done_count", doneCount - doneSnap, 32'd1);

    // Test 6: reset during CLEAR, then write+commit in one cycle
    $display("[TB] test 6: reset during clear");
    applyStimulus(1'b1, 3'd0, 32'h0000_1000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    checkOutput("t6_b0_swapped", b0_out, 32'h1000);
    checkOutput("t6_fc_high", filt_clear, 32'h1);
    idle(1);
    doneSnap = doneCount;
    rst_n = 1'b0;
    idle(1);
    checkOutput("t6_rst_b0", b0_out, 32'h0);
    checkOutput("t6_rst_a1", a1_out, 32'h0);
    checkOutput("t6_rst_fc", filt_clear, 32'h0);
    checkOutput("t6_rst_busy", busy, 32'h0);
    checkOutput("t6_rst_sat", sat_flag, 32'h0);
    rst_n = 1'b1;
    idle(4);
    checkOutput("t6_no_done", doneCount - doneSnap, 32'd0);
    checkOutput("t6_idle", busy, 32'h0);
    applyStimulus(1'b1, 3'd2, 32'hFFFF_8000, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_min_no_sat", sat_flag, 32'h0);
    applyStimulus(1'b1, 3'd1, 32'h0000_7FFF, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_max_no_sat", sat_flag, 32'h0);
    checkOutput("t6_wr_commit_err", wr_err, 32'h0);
    applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(1);
    checkOutput("t6_b1", b1_out, 32'h7FFF);
    checkOutput("t6_b2", b2_out, 32'h8000);
    checkOutput("t6_b0_zero", b0_out, 32'h0);
    checkOutput("t6_done", commit_done, 32'h1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
